move_validator_board: RTL

//   Parametrised successor of the tic-tac-toe move validator: holds an NxN board of owner cells, accepts
//   one move request at a time, rejects illegal moves, commits legal ones, then scans every line for a win.

---
 rtl/tictac_pkg.sv | 26 ++
 rtl/board_cell_array.sv | 60 ++++++
 rtl/move_validator_board.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tictac_pkg.sv
// rtl/tictac_pkg.sv - shared state encoding and line geometry for the move validator board
package tictac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    RESULT_OK,
    RESULT_BAD
  } state_t;

  localparam int CELL_EMPTY = 0;

  // Lines 0..n-1 are rows, n..2n-1 columns, 2n the main diagonal, 2n+1 the anti-diagonal.
  function automatic int line_cell_idx(input int line, input int k, input int n);
    if (line < n) begin
      return line * n + k;
    end else if (line < 2 * n) begin
      return k * n + (line - n);
    end else if (line == 2 * n) begin
      return k * n + k;
    end
    return k * n + (n - 1 - k);
  endfunction

endpackage

// File: rtl/board_cell_array.sv
// rtl/board_cell_array.sv - NxN owner register file with one write port and check/line/render read ports
module board_cell_array
  import tictac_pkg::*;
#(
  parameter int N      = 3,
  parameter int CELL_W = 2,
  parameter int POS_W  = 4,
  parameter int LINE_W = 3
) (
  input  logic                  clock,
  input  logic                  clr,
  input  logic                  we,
  input  logic [POS_W-1:0]      waddr,
  input  logic [CELL_W-1:0]     wdata,
  input  logic [POS_W-1:0]      chk_addr,
  output logic [CELL_W-1:0]     chk_cell,
  input  logic [LINE_W-1:0]     line_sel,
  output logic [N*CELL_W-1:0]   line_cells,
  input  logic [POS_W-1:0]      rd_addr,
  output logic [CELL_W-1:0]     rd_cell
);

  localparam int NUM_CELLS = N * N;
  localparam logic [POS_W:0] CELLS_LIM = (POS_W + 1)'(NUM_CELLS);

  logic [CELL_W-1:0] cells [NUM_CELLS];

  always_ff @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells[i] <= '0;
      end
    end else if (we && ({1'b0, waddr} < CELLS_LIM)) begin
      cells[waddr] <= wdata;
    end
  end

  always_comb begin
    chk_cell = '0;
    if ({1'b0, chk_addr} < CELLS_LIM) begin
      chk_cell = cells[chk_addr];
    end
  end

  always_comb begin
    rd_cell = '0;
    if ({1'b0, rd_addr} < CELLS_LIM) begin
      rd_cell = cells[rd_addr];
    end
  end

  // All N cells of the selected line, cell k in slice k.
  always_comb begin
    line_cells = '0;
    for (int k = 0; k < N; k++) begin
      line_cells[k*CELL_W +: CELL_W] = cells[POS_W'(line_cell_idx(int'(line_sel), k, N))];
    end
  end

endmodule

// File: rtl/move_validator_board.sv
// rtl/move_validator_board.sv - validates and commits board moves, then scans all lines for a win
module move_validator_board
  import tictac_pkg::*;
#(
  parameter int N           = 3,
  parameter int NUM_PLAYERS = 2,
  localparam int POS_W  = $clog2(N * N),
  localparam int PID_W  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CELL_W = $clog2(NUM_PLAYERS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_board,
  input  logic              move_req,
  input  logic [PID_W-1:0]  player_id,
  input  logic [POS_W-1:0]  position,
  output logic              busy,
  output logic              move_done,
  output logic              move_invalid,
  output logic              win,
  output logic [PID_W-1:0]  winner_id,
  output logic              board_full,
  output logic              game_over,
  input  logic [POS_W-1:0]  rd_pos,
  output logic [CELL_W-1:0] rd_cell
);

  localparam int LINE_W = $clog2(2 * N + 2);
  localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(2 * N + 1);
  localparam logic [POS_W:0]    CELLS_LIM   = (POS_W + 1)'(N * N);
  localparam logic [PID_W:0]    PLAYERS_LIM = (PID_W + 1)'(NUM_PLAYERS);

  state_t              state;
  logic [PID_W-1:0]    lat_pid;
  logic [POS_W-1:0]    lat_pos;
  logic [LINE_W-1:0]   line_idx;
  logic [POS_W:0]      cell_count;
  logic                clr;
  logic                legal;
  logic                we;
  logic                line_match;
  logic [CELL_W-1:0]   pid_cell;
  logic [CELL_W-1:0]   chk_cell;
  logic [N*CELL_W-1:0] line_cells;

  assign clr       = reset | clear_board;
  assign pid_cell  = CELL_W'(lat_pid) + CELL_W'(1);
  assign game_over = win | board_full;
  assign legal     = ({1'b0, lat_pos} < CELLS_LIM) && ({1'b0, lat_pid} < PLAYERS_LIM) &&
                     (chk_cell == CELL_W'(CELL_EMPTY)) && !game_over;
  assign we        = (state == CHECK) && legal;

  always_comb begin
    line_match = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (line_cells[k*CELL_W +: CELL_W] != pid_cell) line_match = 1'b0;
    end
  end

  board_cell_array #(
    .N      (N),
    .CELL_W (CELL_W),
    .POS_W  (POS_W),
    .LINE_W (LINE_W)
  ) u_cells (
    .clock      (clock),
    .clr        (clr),
    .we         (we),
    .waddr      (lat_pos),
    .wdata      (pid_cell),
    .chk_addr   (lat_pos),
    .chk_cell   (chk_cell),
    .line_sel   (line_idx),
    .line_cells (line_cells),
    .rd_addr    (rd_pos),
    .rd_cell    (rd_cell)
  );

  // Outputs are registered against the state being entered so pulses line up with RESULT_*.
  always_ff @(posedge clock) begin
    if (clr) begin
      state        <= IDLE;
      lat_pid      <= '0;
      lat_pos      <= '0;
      line_idx     <= '0;
      cell_count   <= '0;
      busy         <= 1'b0;
      move_done    <= 1'b0;
      move_invalid <= 1'b0;
      win          <= 1'b0;
      winner_id    <= '0;
      board_full   <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_invalid <= 1'b0;
      case (state)
        IDLE: begin
          if (move_req) begin
            lat_pid <= player_id;
            lat_pos <= position;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (legal) begin
            cell_count <= cell_count + (POS_W + 1)'(1);
            line_idx   <= '0;
            state      <= SCAN;
          end else begin
            move_invalid <= 1'b1;
            state        <= RESULT_BAD;
          end
        end
        SCAN: begin
          if (line_match) begin
            win       <= 1'b1;
            winner_id <= lat_pid;
          end
          if (line_idx == LAST_LINE) begin
            move_done  <= 1'b1;
            board_full <= (cell_count == CELLS_LIM);
            state      <= RESULT_OK;
          end else begin
            line_idx <= line_idx + LINE_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
